// File: rtl/multiword_add_ctrl.sv
// Multi-precision adder sequencer: one shared XLEN-bit ripple-carry adder, one word per clock, LSW first.
// Optional macro SUB_MODE_EN adds a 'sub' input that turns the operation into A - B.

module multiword_add_rca #(
  parameter int XLEN = 8
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN-1:0] sum,
  output logic            cout
);
  logic [XLEN:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < XLEN; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[XLEN];
endmodule

module multiword_add_ctrl #(
  parameter int XLEN  = 8,
  parameter int WORDS = 4,
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int OPW  = XLEN * WORDS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OPW-1:0]  A,
  input  logic [OPW-1:0]  B,
  input  logic            carry_in,
  output logic            busy,
  output logic            done,
  output logic [OPW:0]    result,
  output logic [IDXW-1:0] word_idx
`ifdef SUB_MODE_EN
  ,
  input  logic            sub
`endif
);
  // state   | meaning
  // S_IDLE  | waiting for start; result holds the last sum
  // S_RUN   | adding word[word_idx], carry kept in carry_q
  // S_DONE  | one-cycle done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [OPW-1:0]  a_q, b_q;
  logic            carry_q;
  logic [OPW-1:0]  b_load;
  logic            cin_load;
  logic [XLEN-1:0] a_word, b_word, sum_word;
  logic            cout_word;
  logic            accept, last;

`ifdef SUB_MODE_EN
  // Subtraction as A + ~B + 1: invert B once at load time, force the initial carry.
  assign b_load   = sub ? ~B : B;
  assign cin_load = sub | carry_in;
`else
  assign b_load   = B;
  assign cin_load = carry_in;
`endif

  assign accept = (state == S_IDLE) && start;
  assign last   = (word_idx == IDXW'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (word_idx == IDXW'(w)) begin
        a_word = a_q[w*XLEN +: XLEN];
        b_word = b_q[w*XLEN +: XLEN];
      end
    end
  end

  multiword_add_rca #(.XLEN(XLEN)) u_rca (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q),
    .sum  (sum_word),
    .cout (cout_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result   <= '0;
      word_idx <= '0;
    end else if (accept) begin
      a_q      <= A;
      b_q      <= b_load;
      carry_q  <= cin_load;
      result   <= '0;
      word_idx <= '0;
    end else if (state == S_RUN) begin
      for (int w = 0; w < WORDS; w++) begin
        if (word_idx == IDXW'(w)) result[w*XLEN +: XLEN] <= sum_word;
      end
      carry_q <= cout_word;
      // The index parks on the last word; the next accept rewinds it.
      if (last) result[OPW] <= cout_word;
      else      word_idx    <= word_idx + IDXW'(1);
    end
  end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed bench for multiword_add_ctrl (XLEN=8, WORDS=4); sub-mode vectors run when SUB_MODE_EN is defined.

module tb_multiword_add_ctrl;
  localparam int XLEN  = 8;
  localparam int WORDS = 4;
  localparam int OPW   = XLEN * WORDS;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [OPW-1:0] A, B;
  logic           carry_in;
  logic           busy, done;
  logic [OPW:0]   result;
  logic [1:0]     word_idx;
`ifdef SUB_MODE_EN
  logic           sub;
`endif

  int vectors    = 0;
  int miscompares = 0;

  multiword_add_ctrl #(.XLEN(XLEN), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .word_idx (word_idx)
`ifdef SUB_MODE_EN
    ,
    .sub      (sub)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full operation; operands are scrambled right after accept to show they are not re-sampled.
  task automatic run_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic cin,
                        input logic sb, input logic [OPW:0] exp, input string tag);
    @(negedge clk);
    A = a; B = b; carry_in = cin; start = 1'b1;
`ifdef SUB_MODE_EN
    sub = sb;
`endif
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; carry_in = ~cin;
`ifdef SUB_MODE_EN
    sub = ~sb;
`endif
    for (int i = 0; i < WORDS; i++) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_idx"}, 64'(word_idx), 64'(i));
      chk({tag, "_nodone"}, 64'(done), 64'd0);
      if (i < WORDS - 1) @(negedge clk);
    end
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'(exp));
    @(negedge clk);
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, 64'(result), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; carry_in = 1'b0;
`ifdef SUB_MODE_EN
    sub = 1'b0;
`endif
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_idx", 64'(word_idx), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000, "carry_chain");
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 33'h0_2345_678A, "cin_one");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF, "all_ones");

    // start pulsed mid-RUN must be dropped, not queued
    @(negedge clk);
    A = 32'h0000_0003; B = 32'h0000_0004; carry_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("ign_idx1", 64'(word_idx), 64'd1);
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_result", 64'(result), 64'h7);
    @(negedge clk);
    chk("ign_done_drop", 64'(done), 64'd0);
    chk("ign_idle1", 64'(busy), 64'd0);
    @(negedge clk);
    chk("ign_idle2", 64'(busy), 64'd0);
    chk("ign_result_hold", 64'(result), 64'h7);

    // start held high through DONE is taken on the first IDLE cycle
    @(negedge clk);
    A = 32'h0000_00FF; B = 32'h0000_0001; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 32'h0000_0010; B = 32'h0000_0020;
    chk("hold_idx0", 64'(word_idx), 64'd0);
    repeat (WORDS) @(negedge clk);
    chk("hold_done", 64'(done), 64'd1);
    chk("hold_result", 64'(result), 64'h100);
    @(negedge clk);
    chk("hold_idle_busy", 64'(busy), 64'd0);
    chk("hold_idle_done", 64'(done), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("hold_reaccept_busy", 64'(busy), 64'd1);
    chk("hold_reaccept_clear", 64'(result), 64'd0);
    repeat (WORDS) @(negedge clk);
    chk("hold2_done", 64'(done), 64'd1);
    chk("hold2_result", 64'(result), 64'h30);

    // async reset in the middle of an operation
    @(negedge clk);
    A = 32'h1020_3040; B = 32'h0101_0101; carry_in = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_idx2", 64'(word_idx), 64'd2);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_idx", 64'(word_idx), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0002, "after_abort");

`ifdef SUB_MODE_EN
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 33'h0_FFFF_FFFE, "sub_borrow");
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 33'h1_0000_0002, "sub_noborrow");
    run_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b0, 33'h0_0000_000C, "sub_off_add");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
